bus_dev_port: RTL

Per-device endpoint that connects one device to the shared bus generator/arbiter. It sits directly upstream and downstream of the bus: the TX queue buffers the device's outgoing packets and presents them to the bus as `pndng`/`D_pop`, and the arbiter drains it with `pop`. The RX side captures packets the bus delivers through `push`/`D_push`, checks their destination, and hands them to the device over a valid/ack handshake. One instance is placed per bus driver slot.

---
 rtl/bus_dev_port.sv | 114 +++++++++++
 1 files changed

// File: rtl/bus_dev_port.sv
// Per-device bus endpoint: show-ahead TX queue drained by the arbiter, plus an
// RX holding register with destination filtering and a valid/ack handshake.
module bus_dev_port #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_push,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  output logic [$clog2(depth):0]     tx_count,
  output logic                       tx_ovf,
  output logic                       tx_udf,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       rx_valid,
  output logic [pckg_sz-1:0]         rx_data,
  input  logic                       rx_ack,
  output logic [7:0]                 rx_drop_cnt,
  output logic                       rx_misroute
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [pckg_sz-1:0] r_mem [depth];
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic               r_tx_ovf;
  logic               r_tx_udf;

  logic               r_rx_valid;
  logic [pckg_sz-1:0] r_rx_data;
  logic [7:0]         r_rx_drop_cnt;
  logic               r_rx_misroute;

  logic               w_empty;
  logic               w_full;
  logic               w_do_push;
  logic               w_do_pop;
  logic [7:0]         w_dest;
  logic               w_match;
  logic               w_rx_load;
  logic               w_rx_drop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(depth));
  // A push into a full queue is still accepted when the same edge frees a slot.
  assign w_do_push = tx_push && (!w_full || pop);
  assign w_do_pop  = pop && !w_empty;

  assign w_dest    = D_push[pckg_sz-1 -: 8];
  assign w_match   = (w_dest == id) || (w_dest == broadcast);
  assign w_rx_load = push && w_match && (!r_rx_valid || rx_ack);
  assign w_rx_drop = push && w_match && r_rx_valid && !rx_ack;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_tx_ovf <= 1'b0;
      r_tx_udf <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      if (tx_push && !w_do_push) r_tx_ovf <= 1'b1;
      if (pop && w_empty)        r_tx_udf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_valid    <= 1'b0;
      r_rx_data     <= '0;
      r_rx_drop_cnt <= 8'd0;
      r_rx_misroute <= 1'b0;
    end else begin
      if (w_rx_load) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= D_push;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_drop && (r_rx_drop_cnt != 8'hFF)) r_rx_drop_cnt <= r_rx_drop_cnt + 8'd1;
      if (push && !w_match) r_rx_misroute <= 1'b1;
    end
  end

  assign tx_full     = w_full;
  assign tx_count    = r_count;
  assign tx_ovf      = r_tx_ovf;
  assign tx_udf      = r_tx_udf;
  assign pndng       = !w_empty;
  assign D_pop       = r_mem[r_rd_ptr];
  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign rx_drop_cnt = r_rx_drop_cnt;
  assign rx_misroute = r_rx_misroute;

endmodule
